div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin arbiter and sequencer that shares one 32/16 restoring divider among N requesters. It picks a requester, loads the divider's operands, pulses its start, and waits for its ready flag. It then returns the quotient and remainder on a shared result bus with a one-hot done pulse. It sits between the requesting pipeline stages and the single divider instance.

## Interface
- N, 4: number of requesters (2..8)
- clk  in  1  clock, rising edge
- clr  in  1  synchronous active-high reset
- req  in  N  request per requester; bit i high = requester i wants a divide
- a_in  in  32*N  dividends; slice i = a_in[32*i+31:32*i]
- b_in  in  16*N  divisors; slice i = b_in[16*i+15:16*i]
- gnt  out  N  one-hot grant pulse; operands of that requester captured
- done  out  N  one-hot completion pulse
- q_out  out  32  quotient, valid while done≠0, held until next done
- r_out  out  16  remainder, same validity as q_out
- dz_out  out  1  divide-by-zero flag, same validity as q_out
- busy  out  1  high whenever state≠IDLE
- div_a  out  32  divider dividend, registered
- div_b  out  16  divider divisor, registered
- div_start  out  1  divider start pulse
- div_clrn  out  1  divider reset, equal to ~clr combinationally
- div_q  in  32  divider quotient
- div_r  in  16  divider remainder
- div_ready  in  1  divider ready; sticky until next start

## Operation
- Clock is `clk`. Reset is `clr`: synchronous, active-high.
- FSM states: IDLE, START, WAIT, DONE.
- **IDLE**
  - If req≠0, select winner idx: first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Latch idx, div_a←a slice, div_b←b slice.
  - Go to START. Otherwise stay in IDLE.
- **START** (one cycle)
  - gnt[idx]=1, div_start=1. Go to WAIT.
- **WAIT**
  - div_start=0.
  - When div_ready=1: capture q_out←div_q, r_out←div_r, dz_out←0. Go to DONE.
- **DONE** (one cycle)
  - done[idx]=1.
  - ptr←(idx+1) mod N. Go to IDLE.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - Drop req in the gnt cycle or the next cycle.
  - req still high when FSM re-enters IDLE counts as a new request.
- Requests arriving while busy wait; at most one operation is in flight.
- Reset values: state=IDLE, ptr=0, gnt=0, done=0, div_start=0, busy=0, q_out=0, r_out=0, dz_out=0, div_a=0, div_b=0.
- clr mid-operation aborts the operation: no done for the aborted requester, FSM to IDLE. div_clrn resets the divider in the same cycle.

## Timing
- req first high in IDLE cycle T:
  - gnt and div_start in T+1.
  - Divider iterates 32 edges.
  - div_ready visible in T+34.
  - done, q_out, r_out in T+35.
  - IDLE again in T+36.
- Back-to-back throughput: one divide per 36 cycles.
- Fairness: with all N requesting continuously, each is served once every N operations, in rotating order.
- gnt, done and div_start are single-cycle pulses, never asserted for two consecutive cycles.

## Configuration
- Macro `DIV_ARB_DZ_EN`.
- **Defined:** in IDLE, a winner with b slice = 0 is flagged.
  - START asserts gnt but not div_start.
  - START goes directly to DONE with q_out=32'hFFFFFFFF, r_out=a[15:0], dz_out=1.
  - done appears in T+2; next IDLE in T+3.
  - Results equal what the divider itself returns for b=0.
- **Undefined:** b=0 is dispatched to the divider like any other value. Full 35-cycle latency; dz_out is constant 0.

## Test plan
1. Reset, then req=4'b0001, a=100, b=7 → gnt[0] at T+1, done[0] at T+35, q_out=14, r_out=2, busy low at T+36.
2. req=4'b1111 held continuously with distinct operands → done order 0,1,2,3,0; each q/r correct; no two consecutive gnts to the same index.
3. After serving index 2, req=4'b0101 → index 0 granted first (ptr=3 wraps to 0), then index 2.
4. a=32'hFFFFFFFF, b=16'hFFFF → q_out=32'h00010001, r_out=0; a=5, b=9 → q_out=0, r_out=5.
5. clr pulsed at T+20 of an operation → no done; all outputs at reset values next cycle; a new req afterwards completes correctly with 35-cycle latency.
6. b=0, a=32'h1234ABCD:
   - with `DIV_ARB_DZ_EN` → done at T+2, q_out=32'hFFFFFFFF, r_out=16'hABCD, dz_out=1.
   - without it → done at T+35, same q/r, dz_out=0.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Bundle between the requesting stages, the shared divider and div_arbiter.
// slave = arbiter side, master = requesters plus divider side.
interface div_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]    req;
    logic [32*N-1:0] a_in;
    logic [16*N-1:0] b_in;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [31:0]     q_out;
    logic [15:0]     r_out;
    logic            dz_out;
    logic            busy;
    logic [31:0]     div_a;
    logic [15:0]     div_b;
    logic            div_start;
    logic            div_clrn;
    logic [31:0]     div_q;
    logic [15:0]     div_r;
    logic            div_ready;

    modport slave (
        input  req, a_in, b_in, div_q, div_r, div_ready,
        output gnt, done, q_out, r_out, dz_out, busy,
        output div_a, div_b, div_start, div_clrn
    );

    modport master (
        output req, a_in, b_in, div_q, div_r, div_ready,
        input  gnt, done, q_out, r_out, dz_out, busy,
        input  div_a, div_b, div_start, div_clrn
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one 32/16 divider among N requesters.
// Optional DIV_ARB_DZ_EN: divide-by-zero shortcut that bypasses the divider.
module div_arbiter #(
    parameter int N = 4
) (
    input logic        clk,
    input logic        clr,
    div_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  done_q, done_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic [31:0]   q_q, q_d;
    logic [15:0]   r_q, r_d;
    logic [31:0]   a_q, a_d;
    logic [15:0]   b_q, b_d;
`ifdef DIV_ARB_DZ_EN
    logic          zf_q, zf_d;
    logic          dz_q, dz_d;
`endif

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [31:0]   a_sel;
    logic [15:0]   b_sel;

    assign a_sel = bus.a_in[32*win_idx +: 32];
    assign b_sel = bus.b_in[16*win_idx +: 16];

    // Rotating-priority winner: lowest offset from ptr wins
    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        jj      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            jj = IW'(j);
            if (bus.req[jj]) begin
                win_vld = 1'b1;
                win_idx = jj;
            end
        end
    end

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = '0;
        done_d  = '0;
        start_d = 1'b0;
        busy_d  = busy_q;
        q_d     = q_q;
        r_d     = r_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef DIV_ARB_DZ_EN
        zf_d    = zf_q;
        dz_d    = dz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    idx_d          = win_idx;
                    a_d            = a_sel;
                    b_d            = b_sel;
                    gnt_d[win_idx] = 1'b1;
                    start_d        = 1'b1;
                    busy_d         = 1'b1;
                    state_d        = START;
`ifdef DIV_ARB_DZ_EN
                    zf_d    = (b_sel == 16'd0);
                    start_d = (b_sel != 16'd0);
`endif
                end
            end
            START: begin
                state_d = WAIT;
`ifdef DIV_ARB_DZ_EN
                if (zf_q) begin
                    done_d[idx_q] = 1'b1;
                    q_d           = 32'hFFFF_FFFF;
                    r_d           = a_q[15:0];
                    dz_d          = 1'b1;
                    state_d       = DONE;
                end
`endif
            end
            WAIT: begin
                if (bus.div_ready) begin
                    done_d[idx_q] = 1'b1;
                    q_d           = bus.div_q;
                    r_d           = bus.div_r;
`ifdef DIV_ARB_DZ_EN
                    dz_d          = 1'b0;
`endif
                    state_d       = DONE;
                end
            end
            DONE: begin
                ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef DIV_ARB_DZ_EN
            zf_q    <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            r_q     <= r_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef DIV_ARB_DZ_EN
            zf_q    <= zf_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.div_start = start_q;
    assign bus.busy      = busy_q;
    assign bus.q_out     = q_q;
    assign bus.r_out     = r_q;
    assign bus.div_a     = a_q;
    assign bus.div_b     = b_q;
    assign bus.div_clrn  = ~clr;
`ifdef DIV_ARB_DZ_EN
    assign bus.dz_out    = dz_q;
`else
    assign bus.dz_out    = 1'b0;
`endif
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural 32-edge divider plus directed vectors.
// Honours DIV_ARB_DZ_EN for the divide-by-zero expectations.
module tb_div_arbiter;
    logic clk = 1'b0;
    logic clr = 1'b1;

    always #5 clk = ~clk;

    div_arbiter_if #(.N(4)) bus ();

    div_arbiter #(.N(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tot_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    // Behavioural divider: start sampled on an edge, ready 32 edges later
    logic [5:0]  dcnt;
    logic        drdy;
    logic [31:0] dla, dq;
    logic [15:0] dlb, dr;

    always @(posedge clk) begin
        if (!bus.div_clrn) begin
            dcnt <= '0;
            drdy <= 1'b0;
            dq   <= '0;
            dr   <= '0;
        end else if (bus.div_start) begin
            dcnt <= 6'd32;
            drdy <= 1'b0;
            dla  <= bus.div_a;
            dlb  <= bus.div_b;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 6'd1;
            if (dcnt == 6'd1) begin
                drdy <= 1'b1;
                dq   <= (dlb == 0) ? 32'hFFFF_FFFF : dla / {16'd0, dlb};
                dr   <= (dlb == 0) ? dla[15:0]
                                   : 16'(dla % {16'd0, dlb});
            end
        end
    end

    assign bus.div_q     = dq;
    assign bus.div_r     = dr;
    assign bus.div_ready = drdy;

    // Pulse outputs must never stay high two cycles in a row
    int          viol = 0;
    logic [3:0]  pg = '0, pd = '0;
    logic        ps = 1'b0;
    always @(negedge clk) begin
        if ((bus.gnt != 0 && pg != 0) || (bus.done != 0 && pd != 0) ||
            (bus.div_start && ps))
            viol++;
        pg = bus.gnt;
        pd = bus.done;
        ps = bus.div_start;
    end

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vec[6];

    task automatic run_op(input int idx, input logic [31:0] a,
                          input logic [15:0] b,
                          output int lg, output int ld,
                          output logic [31:0] q, output logic [15:0] r,
                          output logic dz, output logic [3:0] dv,
                          output logic bz_g, output logic bz_end);
        @(negedge clk);
        bus.req              = '0;
        bus.req[idx]         = 1'b1;
        bus.a_in[idx*32 +: 32] = a;
        bus.b_in[idx*16 +: 16] = b;
        lg = -1; ld = -1; q = '0; r = '0; dz = 1'b0; dv = '0;
        bz_g = 1'b0; bz_end = 1'b1;
        for (int k = 1; k <= 80 && ld < 0; k++) begin
            @(negedge clk);
            if (bus.gnt[idx] && lg < 0) begin
                lg   = k;
                bz_g = bus.busy;
                bus.req[idx] = 1'b0;
            end
            if (bus.done != 0) begin
                ld = k;
                dv = bus.done;
                q  = bus.q_out;
                r  = bus.r_out;
                dz = bus.dz_out;
            end
        end
        bus.req = '0;
        @(negedge clk);
        bz_end = bus.busy;
    endtask

    initial begin
        int          lg, ld;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz, bg, be;
        logic [3:0]  dv;
        int          ord[$];
        logic [31:0] oq[$];
        logic [15:0] orr[$];
        int          nd;
        logic [3:0]  one;

        vec[0] = '{0, 32'd100,        16'd7,      32'd14,         16'd2,      1'b0, 35};
        vec[1] = '{1, 32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'd0,      1'b0, 35};
        vec[2] = '{2, 32'd5,          16'd9,      32'd0,          16'd5,      1'b0, 35};
        vec[3] = '{3, 32'd1000,       16'd10,     32'd100,        16'd0,      1'b0, 35};
        vec[4] = '{1, 32'h1234_5678,  16'h1000,   32'h0001_2345,  16'h0678,   1'b0, 35};
`ifdef DIV_ARB_DZ_EN
        vec[5] = '{3, 32'h1234_ABCD,  16'd0,      32'hFFFF_FFFF,  16'hABCD,   1'b1, 2};
`else
        vec[5] = '{3, 32'h1234_ABCD,  16'd0,      32'hFFFF_FFFF,  16'hABCD,   1'b0, 35};
`endif

        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        clr      = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_clrn",  64'(bus.div_clrn), 64'd0);
        chk("rst_gnt",   64'(bus.gnt), 64'd0);
        chk("rst_done",  64'(bus.done), 64'd0);
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_start", 64'(bus.div_start), 64'd0);
        chk("rst_q",     64'(bus.q_out), 64'd0);
        chk("rst_r",     64'(bus.r_out), 64'd0);
        chk("rst_diva",  64'(bus.div_a), 64'd0);
        clr = 1'b0;
        #1 chk("clrn_hi", 64'(bus.div_clrn), 64'd1);

        foreach (vec[i]) begin
            run_op(vec[i].idx, vec[i].a, vec[i].b, lg, ld, q, r, dz, dv, bg, be);
            one = '0;
            one[vec[i].idx] = 1'b1;
            chk($sformatf("v%0d_gnt_lat", i), 64'(lg), 64'(1));
            chk($sformatf("v%0d_busy_g", i), 64'(bg), 64'd1);
            chk($sformatf("v%0d_done_lat", i), 64'(ld), 64'(vec[i].lat));
            chk($sformatf("v%0d_done_vec", i), 64'(dv), 64'(one));
            chk($sformatf("v%0d_q", i), 64'(q), 64'(vec[i].q));
            chk($sformatf("v%0d_r", i), 64'(r), 64'(vec[i].r));
            chk($sformatf("v%0d_dz", i), 64'(dz), 64'(vec[i].dz));
            chk($sformatf("v%0d_busy_end", i), 64'(be), 64'd0);
        end

        // All four requesting continuously from ptr=0
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.a_in[i*32 +: 32] = 32'(1000 * (i + 1) + i);
            bus.b_in[i*16 +: 16] = 16'(i + 3);
        end
        bus.req = 4'b1111;
        nd = 0;
        for (int k = 0; k < 400 && nd < 5; k++) begin
            @(negedge clk);
            if (bus.done != 0) begin
                ord.push_back(bus.done[0] ? 0 : bus.done[1] ? 1 :
                              bus.done[2] ? 2 : 3);
                oq.push_back(bus.q_out);
                orr.push_back(bus.r_out);
                nd++;
                if (nd == 5) bus.req = '0;
            end
        end
        bus.req = '0;
        chk("rr_count", 64'(nd), 64'd5);
        while (ord.size() < 5) begin
            ord.push_back(-1); oq.push_back('0); orr.push_back('0);
        end
        chk("rr_ord0", 64'(ord[0]), 64'd0);
        chk("rr_ord1", 64'(ord[1]), 64'd1);
        chk("rr_ord2", 64'(ord[2]), 64'd2);
        chk("rr_ord3", 64'(ord[3]), 64'd3);
        chk("rr_ord4", 64'(ord[4]), 64'd0);
        chk("rr_q0", 64'(oq[0]), 64'd333);
        chk("rr_r0", 64'(orr[0]), 64'd1);
        chk("rr_q1", 64'(oq[1]), 64'd500);
        chk("rr_r1", 64'(orr[1]), 64'd1);
        chk("rr_q2", 64'(oq[2]), 64'd600);
        chk("rr_r2", 64'(orr[2]), 64'd2);
        chk("rr_q3", 64'(oq[3]), 64'd667);
        chk("rr_r3", 64'(orr[3]), 64'd1);
        chk("rr_q4", 64'(oq[4]), 64'd333);
        @(negedge clk);
        chk("rr_idle", 64'(bus.busy), 64'd0);

        // Serve index 2, then 0 and 2 together: pointer wraps to 0
        run_op(2, 32'd50, 16'd7, lg, ld, q, r, dz, dv, bg, be);
        chk("wrap_pre_q", 64'(q), 64'd7);
        chk("wrap_pre_r", 64'(r), 64'd1);
        ord.delete(); oq.delete();
        bus.a_in[0*32 +: 32] = 32'd9;
        bus.b_in[0*16 +: 16] = 16'd2;
        bus.a_in[2*32 +: 32] = 32'd20;
        bus.b_in[2*16 +: 16] = 16'd6;
        bus.req = 4'b0101;
        for (int k = 0; k < 200 && ord.size() < 2; k++) begin
            @(negedge clk);
            if (bus.gnt[0]) bus.req[0] = 1'b0;
            if (bus.gnt[2]) bus.req[2] = 1'b0;
            if (bus.done != 0) begin
                ord.push_back(bus.done[0] ? 0 : bus.done[2] ? 2 : 9);
                oq.push_back(bus.q_out);
            end
        end
        bus.req = '0;
        while (ord.size() < 2) begin
            ord.push_back(-1); oq.push_back('0);
        end
        chk("wrap_first", 64'(ord[0]), 64'd0);
        chk("wrap_second", 64'(ord[1]), 64'd2);
        chk("wrap_q0", 64'(oq[0]), 64'd4);
        chk("wrap_q2", 64'(oq[1]), 64'd3);
        repeat (2) @(negedge clk);

        // Abort mid-operation with clr at T+20
        @(negedge clk);
        bus.req = 4'b0010;
        bus.a_in[1*32 +: 32] = 32'd777;
        bus.b_in[1*16 +: 16] = 16'd5;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.gnt[1]) bus.req[1] = 1'b0;
        end
        clr = 1'b1;
        #1 chk("abort_clrn", 64'(bus.div_clrn), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_q", 64'(bus.q_out), 64'd0);
        chk("abort_r", 64'(bus.r_out), 64'd0);
        chk("abort_diva", 64'(bus.div_a), 64'd0);
        chk("abort_divb", 64'(bus.div_b), 64'd0);
        chk("abort_dz", 64'(bus.dz_out), 64'd0);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done != 0) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        run_op(1, 32'd777, 16'd5, lg, ld, q, r, dz, dv, bg, be);
        chk("post_gnt_lat", 64'(lg), 64'd1);
        chk("post_done_lat", 64'(ld), 64'd35);
        chk("post_q", 64'(q), 64'd155);
        chk("post_r", 64'(r), 64'd2);
        chk("post_done_vec", 64'(dv), 64'(4'b0010));

        chk("pulse_viol", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
